// File: rtl/store_narrow_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : store_narrow_unit                                             |
// | Purpose  : Narrows a MEM-stage store operand to byte/half/word. It       |
// |            replicates the operand across byte lanes, checks alignment,   |
// |            and runs one write on the sram-like data bus. The pipeline    |
// |            stalls until the write is acknowledged or the watchdog fires. |
// | Options  : MISALIGN_EXC_EN - raise ades on a misaligned store instead of |
// |            force-aligning the address.                                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module store_narrow_unit #(
  parameter int ADDR_W = 32,
  parameter int WDOG_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              st_valid,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              stall,
  output logic              done,
  output logic              bus_err,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [WDOG_W-1:0] WDOG_MAX = {WDOG_W{1'b1}};

  logic [1:0]        r_state;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [WDOG_W-1:0] r_wdog;

  logic              w_mis;
  logic              w_accept;
  logic              w_ack;
  logic              w_timeout;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;

  // Reserved size 11 counts as misaligned regardless of address
  assign w_mis = ((st_size == 2'b01) && st_addr[0]) ||
                 ((st_size == 2'b10) && (st_addr[1:0] != 2'b00)) ||
                 (st_size == 2'b11);

  // Lane replication and address/size normalisation of the incoming store
  always_comb begin
    w_wdata = st_data;
    w_addr  = {st_addr[ADDR_W-1:2], 2'b00};
    w_size  = 2'b10;
    case (st_size)
      2'b00: begin
        w_wdata = {4{st_data[7:0]}};
        w_addr  = st_addr;
        w_size  = 2'b00;
      end
      2'b01: begin
        w_wdata = {2{st_data[15:0]}};
        w_addr  = {st_addr[ADDR_W-1:1], 1'b0};
        w_size  = 2'b01;
      end
      default: begin
        w_wdata = st_data;
        w_addr  = {st_addr[ADDR_W-1:2], 2'b00};
        w_size  = 2'b10;
      end
    endcase
  end

`ifdef MISALIGN_EXC_EN
  // A misaligned store is rejected; the exception is raised in the same cycle
  assign ades     = (r_state == S_IDLE) && st_valid && w_mis;
  assign badvaddr = ades ? st_addr : '0;
  assign w_accept = (r_state == S_IDLE) && st_valid && !w_mis;
`else
  // Misaligned stores are force-aligned by w_addr and proceed normally
  assign ades     = 1'b0;
  assign badvaddr = '0;
  assign w_accept = (r_state == S_IDLE) && st_valid;
`endif

  // Completion: same-cycle addr/data handshake in REQ, or data_ok in WAIT
  assign w_ack     = ((r_state == S_REQ) && data_addr_ok && data_data_ok) ||
                     ((r_state == S_WAIT) && data_data_ok);
  assign w_timeout = (r_state != S_IDLE) && (r_wdog == WDOG_MAX);

  assign done       = w_ack || w_timeout;
  assign bus_err    = w_timeout && !w_ack;
  assign stall      = st_valid && !done && !ades;
  assign data_req   = (r_state == S_REQ);
  assign data_wr    = data_req;
  assign data_size  = r_size;
  assign data_addr  = r_addr;
  assign data_wdata = r_wdata;

  // Transaction FSM, captured request fields and busy-cycle watchdog
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_wdog  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_REQ;
            r_size  <= w_size;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_wdog  <= '0;
          end
        end
        S_REQ: begin
          if (done) begin
            r_state <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
            if (data_addr_ok) begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (done) begin
            r_state <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
